// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, widths and helpers for the UART TX arbiter
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int PAD_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int unsigned oh_to_idx(input logic [7:0] oh);
        oh_to_idx = 0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) oh_to_idx = i;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UartTX load/busy signals of the arbiter
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        REQ;
    logic [BYTE_W*NUM_REQ-1:0] DATA;
    logic [NUM_REQ-1:0]        ACK;
    logic [NUM_REQ-1:0]        GNT;
    logic                      TX_LOAD;
    logic [PAD_W+BYTE_W-1:0]   TX_DATA;
    logic                      TX_BUSY;
    logic                      ERR;
    logic                      IDLE;

    modport master (
        output REQ, DATA, TX_BUSY,
        input  ACK, GNT, TX_LOAD, TX_DATA, ERR, IDLE
    );

    modport slave (
        input  REQ, DATA, TX_BUSY,
        output ACK, GNT, TX_LOAD, TX_DATA, ERR, IDLE
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: one-hot winner search upward from PTR with wrap; UART_ARB_FIXED_PRIO_EN forces the search to start at 0
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [PTR_W-1:0]   PTR,
    output logic [NUM_REQ-1:0] GNT,
    output logic               VALID
);
    logic [PTR_W-1:0] start;
    logic             found;
    int               idx;

`ifdef UART_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^PTR;
    assign start = '0;
`else
    assign start = PTR;
`endif

    assign VALID = |REQ;

    // first asserted request at or above start, wrapping back to 0
    always_comb begin
        GNT   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!found && REQ[idx]) begin
                GNT[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartTX between NUM_REQ byte sources; UART_ARB_FIXED_PRIO_EN selects fixed priority
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input logic             CLK_100MHz,
    input logic             RESET_N,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state;
    logic [PTR_W-1:0]        ptr, win, pick_idx, nxt_ptr;
    logic [NUM_REQ-1:0]      pick, ack, gnt;
    logic                    pick_vld, tx_load, err, idle;
    logic [PAD_W+BYTE_W-1:0] tx_data;
    logic [TO_W-1:0]         cnt;

    rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .REQ   (bus.REQ),
        .PTR   (ptr),
        .GNT   (pick),
        .VALID (pick_vld)
    );

    assign pick_idx = PTR_W'(oh_to_idx(8'(pick)));
    assign nxt_ptr  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    assign bus.ACK     = ack;
    assign bus.GNT     = gnt;
    assign bus.TX_LOAD = tx_load;
    assign bus.TX_DATA = tx_data;
    assign bus.ERR     = err;
    assign bus.IDLE    = idle;

    // grant / load / busy-tracking FSM with registered outputs
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            ack     <= '0;
            gnt     <= '0;
            tx_load <= 1'b0;
            tx_data <= '0;
            err     <= 1'b0;
            idle    <= 1'b1;
        end else begin
            ack     <= '0;
            tx_load <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld && !bus.TX_BUSY) begin
                        state   <= LOAD;
                        gnt     <= pick;
                        win     <= pick_idx;
                        tx_data <= {PAD_W'(0), bus.DATA[pick_idx*BYTE_W +: BYTE_W]};
                        tx_load <= 1'b1;
                        ack     <= pick;
                        idle    <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= WAIT_BUSY;
                    cnt   <= '0;
                end
                WAIT_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus.TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        gnt   <= '0;
                        ptr   <= nxt_ptr;
                        idle  <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.TX_BUSY) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= nxt_ptr;
                        idle  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector bench for uart_tx_arbiter with a small UartTX busy model
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int BT = 16;
`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] req;
        logic [15:0]  d;
        logic [N-1:0] ack;
    } vec_t;

    logic CLK_100MHz = 1'b0;
    logic RESET_N    = 1'b0;
    int   passed     = 0;
    int   total      = 0;

    logic bm_en = 1'b1, ext_busy = 1'b0, mbusy = 1'b0;
    int   bm_delay = 2, bm_hold = 4, dcnt = -1, hcnt = 0;

    vec_t tbl[10];

    always #5 CLK_100MHz = ~CLK_100MHz;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT), .TO_W(5)) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET_N    (RESET_N),
        .bus        (bus)
    );

    assign bus.TX_BUSY = mbusy | ext_busy;

    // UartTX stand-in: busy rises bm_delay cycles after LOAD and stays up bm_hold cycles
    always @(posedge CLK_100MHz) begin
        if (!RESET_N) begin
            dcnt  <= -1;
            hcnt  <= 0;
            mbusy <= 1'b0;
        end else if (bus.TX_LOAD && bm_en) begin
            dcnt <= bm_delay - 2;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 0) begin
            mbusy <= 1'b1;
            hcnt  <= bm_hold - 1;
            dcnt  <= -1;
        end else if (mbusy) begin
            if (hcnt == 0) mbusy <= 1'b0;
            else hcnt <= hcnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_load(input string tag, output int n);
        n = 0;
        while (!bus.TX_LOAD && n < 40) begin
            @(negedge CLK_100MHz);
            n++;
        end
        if (!bus.TX_LOAD) check({tag, " load timeout"}, 32'(bus.TX_LOAD), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge CLK_100MHz);
        while (!bus.IDLE && n < 80) begin
            @(negedge CLK_100MHz);
            n++;
        end
        check({tag, " idle"}, 32'(bus.IDLE), 32'd1);
    endtask

    task automatic run_txn(input logic [N-1:0] req, input logic [15:0] d, input logic [N-1:0] a,
                           input string tag);
        int n;
        bus.REQ = req;
        wait_load(tag, n);
        check({tag, " tx_data"}, 32'(bus.TX_DATA), 32'(d));
        check({tag, " ack"}, 32'(bus.ACK), 32'(a));
        check({tag, " gnt"}, 32'(bus.GNT), 32'(a));
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n, extra, gbad;
        bus.REQ  = '0;
        bus.DATA = {8'h44, 8'h33, 8'h22, 8'h11};

        tbl[0] = '{4'b1111, 16'h0011, 4'b0001};
        tbl[1] = '{4'b1111, FIXED ? 16'h0011 : 16'h0022, FIXED ? 4'b0001 : 4'b0010};
        tbl[2] = '{4'b1111, FIXED ? 16'h0011 : 16'h0033, FIXED ? 4'b0001 : 4'b0100};
        tbl[3] = '{4'b1111, FIXED ? 16'h0011 : 16'h0044, FIXED ? 4'b0001 : 4'b1000};
        tbl[4] = '{4'b1111, 16'h0011, 4'b0001};
        tbl[5] = '{4'b1000, 16'h0044, 4'b1000};
        tbl[6] = '{4'b1001, 16'h0011, 4'b0001};
        tbl[7] = '{4'b0101, FIXED ? 16'h0011 : 16'h0033, FIXED ? 4'b0001 : 4'b0100};
        tbl[8] = '{4'b0011, 16'h0011, 4'b0001};
        tbl[9] = '{4'b0110, 16'h0022, 4'b0010};

        repeat (2) @(negedge CLK_100MHz);
        check("rst ack", 32'(bus.ACK), 32'd0);
        check("rst gnt", 32'(bus.GNT), 32'd0);
        check("rst tx_load", 32'(bus.TX_LOAD), 32'd0);
        check("rst tx_data", 32'(bus.TX_DATA), 32'd0);
        check("rst err", 32'(bus.ERR), 32'd0);
        check("rst idle", 32'(bus.IDLE), 32'd1);
        RESET_N = 1'b1;

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].req, tbl[i].d, tbl[i].ack, $sformatf("vec%0d", i));
        bus.REQ = '0;

        // single request: one-cycle latency, byte capture, grant held through the frame
        bm_hold = 20;
        bus.DATA[7:0] = 8'hA5;
        bus.REQ = 4'b0001;
        @(negedge CLK_100MHz);
        check("single tx_load", 32'(bus.TX_LOAD), 32'd1);
        check("single tx_data", 32'(bus.TX_DATA), 32'h00A5);
        check("single ack", 32'(bus.ACK), 32'b0001);
        check("single gnt", 32'(bus.GNT), 32'b0001);
        bus.REQ = '0;
        bus.DATA[7:0] = 8'h00;
        @(negedge CLK_100MHz);
        check("single load pulse", 32'(bus.TX_LOAD), 32'd0);
        check("single ack pulse", 32'(bus.ACK), 32'd0);
        check("single data hold", 32'(bus.TX_DATA), 32'h00A5);
        extra = 0;
        gbad  = 0;
        n     = 0;
        while (!bus.IDLE && n < 60) begin
            if (bus.TX_LOAD) extra++;
            if (bus.GNT != 4'b0001) gbad++;
            @(negedge CLK_100MHz);
            n++;
        end
        check("single extra loads", 32'(extra), 32'd0);
        check("single gnt held", 32'(gbad), 32'd0);
        check("single idle", 32'(bus.IDLE), 32'd1);
        check("single gnt release", 32'(bus.GNT), 32'd0);
        check("single frame length", 32'(n), 32'd22);
        bus.DATA[7:0] = 8'h11;
        bm_hold = 4;

        // busy never rises: ERR exactly BT+1 cycles after LOAD
        bm_en = 1'b0;
        bus.REQ = 4'b0010;
        @(negedge CLK_100MHz);
        check("to load", 32'(bus.TX_LOAD), 32'd1);
        check("to ack", 32'(bus.ACK), FIXED ? 32'b0010 : 32'b0010);
        bus.REQ = '0;
        n = 0;
        while (!bus.ERR && n < 40) begin
            @(negedge CLK_100MHz);
            n++;
        end
        check("to err latency", 32'(n), 32'(BT + 1));
        check("to idle", 32'(bus.IDLE), 32'd1);
        check("to gnt", 32'(bus.GNT), 32'd0);
        @(negedge CLK_100MHz);
        check("to err pulse", 32'(bus.ERR), 32'd0);
        bm_en = 1'b1;
        run_txn(4'b0011, 16'h0011, 4'b0001, "after_to");
        bus.REQ = '0;

        // foreign busy blocks arbitration until it drops
        ext_busy = 1'b1;
        bus.REQ = 4'b0010;
        extra = 0;
        repeat (6) begin
            @(negedge CLK_100MHz);
            if (bus.TX_LOAD) extra++;
        end
        check("ext no load", 32'(extra), 32'd0);
        check("ext idle", 32'(bus.IDLE), 32'd1);
        ext_busy = 1'b0;
        wait_load("ext", n);
        check("ext grant latency", 32'(n <= 2), 32'd1);
        check("ext ack", 32'(bus.ACK), 32'b0010);
        bus.REQ = '0;
        wait_idle("ext");

        // reset during WAIT_DONE, then pending requests restart from requester 0
        bm_hold = 20;
        bus.REQ = 4'b0100;
        wait_load("rst_mid", n);
        check("rst_mid ack", 32'(bus.ACK), FIXED ? 32'b0100 : 32'b0100);
        bus.REQ = '0;
        repeat (4) @(negedge CLK_100MHz);
        check("rst_mid gnt held", 32'(bus.GNT), 32'b0100);
        #2;
        RESET_N = 1'b0;
        bus.REQ = 4'b1111;
        #1;
        check("arst ack", 32'(bus.ACK), 32'd0);
        check("arst gnt", 32'(bus.GNT), 32'd0);
        check("arst tx_load", 32'(bus.TX_LOAD), 32'd0);
        check("arst tx_data", 32'(bus.TX_DATA), 32'd0);
        check("arst err", 32'(bus.ERR), 32'd0);
        check("arst idle", 32'(bus.IDLE), 32'd1);
        repeat (2) @(negedge CLK_100MHz);
        RESET_N = 1'b1;
        bm_hold = 4;
        run_txn(4'b1111, 16'h0011, 4'b0001, "post_rst");
        bus.REQ = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UartTX transmitter between NUM_REQ byte-producing requesters (CPU MemoryMappedIO, debug dumper, test pattern sources).
- Picks one requester round-robin, presents its byte to UartTX, and issues a one-cycle LOAD pulse.
- Tracks TX_BUSY through the full frame, then releases the transmitter.
- Sits between the requesters and the UartTX instance, in the CLK_100MHz domain.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- BUSY_TIMEOUT, 16, cycles to wait for TX_BUSY to rise after LOAD before declaring an error.
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
- CLK_100MHz  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester "byte pending" level.
- DATA  in  8*NUM_REQ  flattened bytes; requester i on bits [8i+7:8i].
- ACK  out  NUM_REQ  one-cycle pulse: requester i's byte was taken.
- GNT  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- TX_LOAD  out  1  to UartTX LOAD.
- TX_DATA  out  16  to UartTX IN; {8'h00, byte}.
- TX_BUSY  in  1  from UartTX TX_BUSY.
- ERR  out  1  one-cycle pulse on BUSY_TIMEOUT expiry.
- IDLE  out  1  high while in the IDLE state.

Behaviour:
- Reset values (asynchronous, RESET_N=0):
  - ACK=0, GNT=0, TX_LOAD=0, TX_DATA=16'h0000, ERR=0, IDLE=1.
  - State=IDLE, round-robin pointer=0, timeout counter=0.
  - Reset mid-frame aborts immediately; the frame already in flight inside UartTX is not tracked.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only when |REQ && !TX_BUSY.
  - Winner is the first set REQ bit searching upward from the pointer, wrapping NUM_REQ-1 -> 0.
  - On the next edge: state -> LOAD, GNT <= one-hot winner, TX_DATA <= {8'h00, DATA[winner]}.
  - If TX_BUSY=1 while idle (foreign or late busy), no grant is made.
- LOAD (exactly one cycle):
  - TX_LOAD=1 and ACK[winner]=1 in the same cycle.
  - Next state is WAIT_BUSY; timeout counter cleared.
  - Latency: REQ sampled at edge k gives TX_LOAD high during cycle k+1.
- WAIT_BUSY:
  - TX_LOAD=0.
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise the counter increments; when it reaches BUSY_TIMEOUT, ERR pulses one cycle and the state goes to IDLE with the pointer advanced.
- WAIT_DONE: holds until TX_BUSY=0, then -> IDLE, GNT <= 0, pointer <= (winner+1) mod NUM_REQ.
- TX_DATA holds its value until the next LOAD.
- Requester contract:
  - Hold REQ and DATA stable until ACK.
  - The byte is captured at the LOAD transition, so DATA may change the cycle after ACK.
  - Dropping REQ before grant withdraws the request cleanly.
  - REQ sampled while not in IDLE has no effect until IDLE.
- Fairness: one byte per grant; a continuously requesting source is followed by every other pending source before it is served again.
- Minimum spacing between LOAD pulses: one IDLE cycle after TX_BUSY falls.
- NUM_REQ=1: the pointer stays 0; behaviour otherwise identical.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: the pointer is ignored; the lowest-index asserted REQ always wins (requester 0 highest priority). Starvation of higher indices is permitted.
- Undefined: round-robin as specified above.
- Timing, ACK/LOAD and ERR behaviour are identical in both builds.

Decomposition:
- Shared package uart_arb_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3);
  - the byte width constant 8;
  - the TX_DATA pad width constant 8.
- One sub-module, rr_picker: combinational REQ plus pointer -> one-hot winner and valid.
  - The fixed-priority variant lives inside it under the macro.

Test Plan:
- Single request: REQ=4'b0001, DATA[0]=8'hA5, UartTX model raises busy 2 cycles after LOAD and holds it 20 cycles -> TX_LOAD one cycle at k+1, TX_DATA=16'h00A5, ACK=4'b0001 with it, GNT=4'b0001 until busy falls, IDLE=1 after.
- All four requesting continuously, bytes 11/22/33/44 -> TX_DATA order 0011, 0022, 0033, 0044, 0011 (fixed-prio build: 0011 repeated).
- Pointer wrap: grant requester 3, then REQ=4'b1001 -> requester 0 served next.
- TX_BUSY never rises after LOAD -> ERR pulses exactly BUSY_TIMEOUT+1 cycles after LOAD, state returns to IDLE, next request still served.
- TX_BUSY held high externally while REQ=4'b0010 -> no TX_LOAD until busy drops; then grant within 2 cycles.
- RESET_N pulled low during WAIT_DONE -> all outputs at reset values asynchronously; after release, pending REQ is served starting from requester 0.
